imm_gen_pipe: RTL and testbench

- Registered, parametrised immediate-generation stage for the RISC-V core.
- Accepts a raw 32-bit instruction over a valid/ready handshake and classifies its immediate format from the opcode.
- Extends the immediate to XLEN and buffers results in a 2-entry output queue.
- Sits between instruction fetch/IR and the decode/execute datapath. Replaces the combinational format select plus extend pair, and adds illegal-opcode flagging and optional CSR zimm support.

---
 rtl/imm_gen_pipe_pkg.sv | 31 +++
 rtl/imm_gen_pipe_extend.sv | 71 +++++++
 rtl/imm_gen_pipe.sv | 153 +++++++++++++++
 tb/tb_imm_gen_pipe.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pipe_pkg.sv
// imm_gen_pipe_pkg
// Shared definitions for the immediate-generation stage: the immediate
// format codes presented on out_sel and the RV32/RV64 base opcodes that the
// format classifier recognises.
package imm_gen_pipe_pkg;

  // Format code carried alongside every generated immediate
  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } imm_fmt_e;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

endpackage

// File: rtl/imm_gen_pipe_extend.sv
// imm_format_extend
// Combinational immediate classifier and extender.
//   instr   [31:0]     raw instruction
//   sel     [2:0]      immediate format code (imm_fmt_e)
//   imm     [XLEN-1:0] immediate, sign-extended (I/S/B/U/J) or zero-extended (Z)
//   illegal            opcode is not one the core recognises
module imm_format_extend
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ENABLE_ZIMM = 1
) (
  input  logic [31:0]     instr,
  output logic [2:0]      sel,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  imm_fmt_e    fmt_s;
  logic        illegal_s;
  logic [31:0] raw_s;
  logic [6:0]  opcode_s;

  assign opcode_s = instr[6:0];

  // Opcode to format classification; known opcodes without an immediate are not illegal
  always_comb begin
    fmt_s     = FMT_NONE;
    illegal_s = 1'b0;
    case (opcode_s)
      OP_IMM, OP_LOAD, OP_JALR: fmt_s = FMT_I;
      OP_STORE:                 fmt_s = FMT_S;
      OP_BRANCH:                fmt_s = FMT_B;
      OP_LUI, OP_AUIPC:         fmt_s = FMT_U;
      OP_JAL:                   fmt_s = FMT_J;
      OP_SYSTEM: begin
        // funct3[2] marks the CSR immediate forms (csrrwi/csrrsi/csrrci)
        if ((ENABLE_ZIMM != 0) && instr[14]) begin
          fmt_s = FMT_Z;
        end else begin
          fmt_s = FMT_NONE;
        end
      end
      OP_R_TYPE, OP_FENCE:      fmt_s = FMT_NONE;
      default: begin
        fmt_s     = FMT_NONE;
        illegal_s = 1'b1;
      end
    endcase
  end

  // Assemble the 32-bit immediate; Z keeps bit 31 clear so the common
  // sign-extension below leaves it zero-extended
  always_comb begin
    raw_s = 32'd0;
    case (fmt_s)
      FMT_I:   raw_s = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   raw_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   raw_s = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   raw_s = {instr[31:12], 12'd0};
      FMT_J:   raw_s = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      FMT_Z:   raw_s = {27'd0, instr[19:15]};
      default: raw_s = 32'd0;
    endcase
  end

  assign imm     = XLEN'($signed(raw_s));
  assign sel     = fmt_s;
  assign illegal = illegal_s;

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe
// Registered immediate-generation stage with a DEPTH-entry (1 or 2) output
// queue. The head entry lives directly in the output registers; with
// DEPTH=2 a second (skid) register holds the entry behind it.
//   clk, resetn        clock, asynchronous active-low reset
//   flush              synchronous queue clear (discards same-cycle push/pop)
//   in_valid/in_ready  instruction handshake, in_instr[31:0]
//   out_valid/out_ready result handshake
//   out_imm[XLEN-1:0], out_sel[2:0], out_illegal  head entry
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ENABLE_ZIMM = 1,
  parameter int DEPTH       = 2
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_sel,
  output logic            out_illegal
);

  localparam logic [1:0] DEPTH_C = 2'(DEPTH);

  logic [2:0]      dec_sel_s;
  logic [XLEN-1:0] dec_imm_s;
  logic            dec_illegal_s;

  logic [1:0]      count_r;
  logic [1:0]      count_nx_s;
  logic            out_valid_r;
  logic [XLEN-1:0] head_imm_r;
  logic [2:0]      head_sel_r;
  logic            head_ill_r;
  logic [XLEN-1:0] skid_imm_r;
  logic [2:0]      skid_sel_r;
  logic            skid_ill_r;

  logic            push_s;
  logic            pop_s;
  logic            head_load_s;
  logic            head_from_skid_s;
  logic            skid_load_s;
  logic [XLEN-1:0] head_imm_nx_s;
  logic [2:0]      head_sel_nx_s;
  logic            head_ill_nx_s;

  imm_format_extend #(
    .XLEN        (XLEN),
    .ENABLE_ZIMM (ENABLE_ZIMM)
  ) u_extend (
    .instr   (in_instr),
    .sel     (dec_sel_s),
    .imm     (dec_imm_s),
    .illegal (dec_illegal_s)
  );

  // in_ready depends only on registered occupancy and flush, never on out_ready
  assign in_ready = (count_r < DEPTH_C) & ~flush;
  assign push_s   = in_valid & in_ready;
  assign pop_s    = out_valid_r & out_ready & ~flush;

  // Occupancy update and head/skid load decisions
  always_comb begin
    count_nx_s       = count_r;
    head_load_s      = 1'b0;
    head_from_skid_s = 1'b0;
    skid_load_s      = 1'b0;
    if (flush) begin
      count_nx_s = 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_nx_s = count_r + 2'd1;
        2'b01:   count_nx_s = count_r - 2'd1;
        default: count_nx_s = count_r;
      endcase
      // A full queue cannot push, so a pop from two entries always promotes the skid
      if (pop_s && (count_r == 2'd2)) begin
        head_load_s      = 1'b1;
        head_from_skid_s = 1'b1;
      end else if (push_s && ((count_r == 2'd0) || pop_s)) begin
        head_load_s = 1'b1;
      end else begin
        head_load_s = 1'b0;
      end
      if (push_s && !pop_s && (count_r == 2'd1)) begin
        skid_load_s = 1'b1;
      end else begin
        skid_load_s = 1'b0;
      end
    end
  end

  // Source select for the head registers
  always_comb begin
    if (head_from_skid_s) begin
      head_imm_nx_s = skid_imm_r;
      head_sel_nx_s = skid_sel_r;
      head_ill_nx_s = skid_ill_r;
    end else begin
      head_imm_nx_s = dec_imm_s;
      head_sel_nx_s = dec_sel_s;
      head_ill_nx_s = dec_illegal_s;
    end
  end

  // Occupancy and valid flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_r     <= 2'd0;
      out_valid_r <= 1'b0;
    end else begin
      count_r     <= count_nx_s;
      out_valid_r <= (count_nx_s != 2'd0);
    end
  end

  // Head and skid payload; the head holds its last value when the queue empties
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_imm_r <= '0;
      head_sel_r <= FMT_NONE;
      head_ill_r <= 1'b0;
      skid_imm_r <= '0;
      skid_sel_r <= FMT_NONE;
      skid_ill_r <= 1'b0;
    end else begin
      if (head_load_s) begin
        head_imm_r <= head_imm_nx_s;
        head_sel_r <= head_sel_nx_s;
        head_ill_r <= head_ill_nx_s;
      end
      if (skid_load_s) begin
        skid_imm_r <= dec_imm_s;
        skid_sel_r <= dec_sel_s;
        skid_ill_r <= dec_illegal_s;
      end
    end
  end

  assign out_valid   = out_valid_r;
  assign out_imm     = head_imm_r;
  assign out_sel     = head_sel_r;
  assign out_illegal = head_ill_r;

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

  localparam int XLEN        = 32;
  localparam int ENABLE_ZIMM = 1;
  localparam int DEPTH       = 2;

  logic            clk = 1'b0;
  logic            resetn;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_sel;
  logic            out_illegal;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [XLEN-1:0] imm;
    logic [2:0]      sel;
    logic            ill;
  } ent_t;

  ent_t exp_q[$];

  imm_gen_pipe #(
    .XLEN        (XLEN),
    .ENABLE_ZIMM (ENABLE_ZIMM),
    .DEPTH       (DEPTH)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_imm     (out_imm),
    .out_sel     (out_sel),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: immediate value computed as a signed integer from the ISA field weights
  function automatic ent_t ref_entry(input logic [31:0] ins);
    ent_t   e;
    longint v;
    v     = 0;
    e.sel = 3'd0;
    e.ill = 1'b0;
    case (ins[6:0])
      7'h13, 7'h03, 7'h67: begin
        e.sel = 3'd1;
        v = longint'(ins[31:20]);
        if (v >= 64'sd2048) v -= 64'sd4096;
      end
      7'h23: begin
        e.sel = 3'd2;
        v = longint'(ins[31:25]) * 64'sd32 + longint'(ins[11:7]);
        if (v >= 64'sd2048) v -= 64'sd4096;
      end
      7'h63: begin
        e.sel = 3'd3;
        v = longint'(ins[31]) * 64'sd4096 + longint'(ins[7]) * 64'sd2048
          + longint'(ins[30:25]) * 64'sd32 + longint'(ins[11:8]) * 64'sd2;
        if (v >= 64'sd4096) v -= 64'sd8192;
      end
      7'h37, 7'h17: begin
        e.sel = 3'd4;
        v = longint'(ins[31:12]) * 64'sd4096;
        if (v >= 64'sd2147483648) v -= 64'sd4294967296;
      end
      7'h6F: begin
        e.sel = 3'd5;
        v = longint'(ins[31]) * 64'sd1048576 + longint'(ins[19:12]) * 64'sd4096
          + longint'(ins[20]) * 64'sd2048 + longint'(ins[30:21]) * 64'sd2;
        if (v >= 64'sd1048576) v -= 64'sd2097152;
      end
      7'h73: begin
        if (ENABLE_ZIMM != 0 && ins[14] == 1'b1) begin
          e.sel = 3'd6;
          v = longint'(ins[19:15]);
        end
      end
      7'h33, 7'h0F: e.sel = 3'd0;
      default: e.ill = 1'b1;
    endcase
    e.imm = v[XLEN-1:0];
    return e;
  endfunction

  // One clock cycle: drive, check against the model, then advance the model
  task automatic cycle(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
    ent_t e;
    logic exp_rdy;
    logic acc;
    logic popd;
    @(negedge clk);
    in_valid  = v;
    in_instr  = ins;
    out_ready = ordy;
    flush     = fl;
    #1;
    exp_rdy = (exp_q.size() < DEPTH) && !fl;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      e = exp_q[0];
      chk("out_imm", 64'(out_imm), 64'(e.imm));
      chk("out_sel", 64'(out_sel), 64'(e.sel));
      chk("out_illegal", 64'(out_illegal), 64'(e.ill));
    end
    acc  = v && exp_rdy;
    popd = (exp_q.size() != 0) && ordy && !fl;
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
    end else begin
      if (popd) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(ref_entry(ins));
    end
    #1;
  endtask

  // Directed check of the registered head against hand-derived constants
  task automatic peek(input string tag, input logic [2:0] sel, input logic [63:0] imm64, input logic ill);
    logic [XLEN-1:0] t;
    t = imm64[XLEN-1:0];
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_sel"}, 64'(out_sel), 64'(sel));
    chk({tag, "_imm"}, 64'(out_imm), 64'(t));
    chk({tag, "_ill"}, 64'(out_illegal), 64'(ill));
  endtask

  logic [6:0] opc_tab [12] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37,
                               7'h17, 7'h6F, 7'h73, 7'h33, 7'h0F, 7'h7F};

  initial begin
    logic [31:0] r;
    logic [31:0] ins;
    logic [6:0]  opc;
    int          k;

    resetn    = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'd0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_imm", 64'(out_imm), 64'd0);
    chk("rst_out_sel", 64'(out_sel), 64'd0);
    chk("rst_out_illegal", 64'(out_illegal), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // First transaction latency
    cycle(1'b1, 32'hFFF00093, 1'b1, 1'b0);
    peek("addi", 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

    // Back-to-back formats
    cycle(1'b1, 32'h12345037, 1'b1, 1'b0);
    peek("lui", 3'd4, 64'h0000_0000_1234_5000, 1'b0);
    cycle(1'b1, 32'hFE112C23, 1'b1, 1'b0);
    peek("store", 3'd2, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
    cycle(1'b1, 32'hFE000EE3, 1'b1, 1'b0);
    peek("branch", 3'd3, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    cycle(1'b1, 32'h0080006F, 1'b1, 1'b0);
    peek("jal", 3'd5, 64'h0000_0000_0000_0008, 1'b0);
    cycle(1'b0, 32'd0, 1'b1, 1'b0);

    // Backpressure: third instruction held until space frees up
    cycle(1'b1, 32'h00500113, 1'b0, 1'b0);
    cycle(1'b1, 32'h80000237, 1'b0, 1'b0);
    cycle(1'b1, 32'h7FF00193, 1'b0, 1'b0);
    cycle(1'b1, 32'h7FF00193, 1'b1, 1'b0);
    cycle(1'b1, 32'h7FF00193, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 1'b1, 1'b0);

    // Illegal opcode and CSR immediate
    cycle(1'b1, 32'h0000007F, 1'b1, 1'b0);
    peek("illegal", 3'd0, 64'd0, 1'b1);
    cycle(1'b1, 32'h00F0F073, 1'b1, 1'b0);
    peek("zimm", (ENABLE_ZIMM != 0) ? 3'd6 : 3'd0, (ENABLE_ZIMM != 0) ? 64'd1 : 64'd0, 1'b0);
    cycle(1'b1, 32'h00000033, 1'b1, 1'b0);
    peek("rtype", 3'd0, 64'd0, 1'b0);
    cycle(1'b0, 32'd0, 1'b1, 1'b0);

    // Flush with a full queue and a same-cycle push
    cycle(1'b1, 32'h00100093, 1'b0, 1'b0);
    cycle(1'b1, 32'h00200093, 1'b0, 1'b0);
    cycle(1'b1, 32'h00300093, 1'b1, 1'b1);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 1'b1, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      r   = $urandom();
      k   = $urandom_range(0, 12);
      opc = (k == 12) ? r[6:0] : opc_tab[k];
      ins = {r[31:7], opc};
      cycle($urandom_range(0, 3) != 0, ins, $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
    end

    // Asynchronous reset between clock edges with data queued
    cycle(1'b1, 32'hFFF00093, 1'b0, 1'b0);
    cycle(1'b1, 32'h12345037, 1'b0, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_imm", 64'(out_imm), 64'd0);
    chk("arst_out_sel", 64'(out_sel), 64'd0);
    chk("arst_out_illegal", 64'(out_illegal), 64'd0);
    exp_q.delete();
    @(negedge clk);
    in_valid = 1'b0;
    resetn   = 1'b1;
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
    cycle(1'b1, 32'h0080006F, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
